// File: rtl/fetch_queue.sv
// Instruction fetch front end: drives sequential fetch addresses, buffers returned words with
// their PCs in a DEPTH-entry FIFO, and redirects/drains on branch targets.
module fetch_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [XLEN-1:0]              start_address,
   input  logic                         redirect_v,
   input  logic [XLEN-1:0]              redirect_adr,
   output logic [XLEN-1:0]              imem_adr,
   input  logic [XLEN-1:0]              imem_resp,
   input  logic                         imem_resp_v,
   output logic [XLEN-1:0]              inst_o,
   output logic [XLEN-1:0]              inst_pc_o,
   output logic                         inst_v_o,
   input  logic                         inst_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   target_pc_q, target_pc_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [XLEN-1:0]   pc_mem_q   [DEPTH];
   logic [XLEN-1:0]   inst_mem_q [DEPTH];

   logic              push, pop, flush;
   logic [XLEN-1:0]   redirect_pc;

   assign redirect_pc = redirect_adr & ~XLEN'(3);

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      target_pc_d = target_pc_q;
      push        = 1'b0;
      flush       = redirect_v && (state_q != S_BOOT);
      pop         = (count_q != '0) && inst_ready_i;
      case (state_q)
         S_BOOT: begin
            fetch_pc_d = start_address & ~XLEN'(3);
            state_d    = S_FETCH;
         end
         S_FETCH: begin
            if (redirect_v) begin
               // A response arriving with the redirect is stale, so restart immediately.
               if (imem_resp_v) begin
                  fetch_pc_d = redirect_pc;
               end else begin
                  target_pc_d = redirect_pc;
                  state_d     = S_DRAIN;
               end
            end else if (imem_resp_v && (count_q != FULL_CNT)) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
         end
         S_DRAIN: begin
            if (redirect_v) begin
               if (imem_resp_v) begin
                  fetch_pc_d = redirect_pc;
                  state_d    = S_FETCH;
               end else begin
                  target_pc_d = redirect_pc;
               end
            end else if (imem_resp_v) begin
               fetch_pc_d = target_pc_q;
               state_d    = S_FETCH;
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_BOOT;
         fetch_pc_q  <= '0;
         target_pc_q <= '0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         target_pc_q <= target_pc_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
      end
   end

   // NOTE: storage is not reset; entries are only visible through count_q, which is.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
         inst_mem_q[wr_ptr_q] <= imem_resp;
      end
   end

   assign imem_adr  = fetch_pc_q;
   assign count_o   = count_q;
   assign inst_v_o  = (count_q != '0);
   assign inst_o    = inst_v_o ? inst_mem_q[rd_ptr_q] : '0;
   assign inst_pc_o = inst_v_o ? pc_mem_q[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: an address-driven imem responder plus a queue-based
// reference model of the fetch/redirect/FIFO rules, compared every cycle.
module tb_fetch_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [XLEN-1:0] start_address = 32'h0001_0000;
   logic            redirect_v = 1'b0;
   logic [XLEN-1:0] redirect_adr = '0;
   logic [XLEN-1:0] imem_adr;
   logic [XLEN-1:0] imem_resp = '0;
   logic            imem_resp_v = 1'b0;
   logic [XLEN-1:0] inst_o, inst_pc_o;
   logic            inst_v_o;
   logic            inst_ready_i = 1'b0;
   logic [CW-1:0]   count_o;

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start_address(start_address),
      .redirect_v(redirect_v), .redirect_adr(redirect_adr),
      .imem_adr(imem_adr), .imem_resp(imem_resp), .imem_resp_v(imem_resp_v),
      .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_v_o(inst_v_o),
      .inst_ready_i(inst_ready_i), .count_o(count_o)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   // reference model
   ent_t        mq[$];
   bit          m_boot, m_drain;
   logic [31:0] m_fetch, m_target;

   // imem responder state
   logic [31:0] last_adr = 'x;
   int          age = 0;
   int          lat = 0;
   int          lat_fixed = 0;
   bit          lat_rand = 1'b0;
   bit          rv;
   bit          applied;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[23:0], 8'h13};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_boot   = 1'b1;
      m_drain  = 1'b0;
      m_fetch  = '0;
      m_target = '0;
   endtask

   task automatic model_update(input bit resp_v, input bit redir, input bit rdy,
                               input logic [31:0] radr);
      bit pop, acc;
      pop = (mq.size() != 0) && rdy;
      if (m_boot) begin
         m_fetch = start_address & ~32'h3;
         m_boot  = 1'b0;
      end else if (redir) begin
         mq.delete();
         if (resp_v) begin
            m_fetch = radr & ~32'h3;
            m_drain = 1'b0;
         end else begin
            m_target = radr & ~32'h3;
            m_drain  = 1'b1;
         end
      end else if (m_drain) begin
         if (pop) void'(mq.pop_front());
         if (resp_v) begin
            m_fetch = m_target;
            m_drain = 1'b0;
         end
      end else begin
         acc = resp_v && (mq.size() < DEPTH);
         if (pop) void'(mq.pop_front());
         if (acc) begin
            mq.push_back('{pc: m_fetch, ins: word(m_fetch)});
            m_fetch = m_fetch + 32'd4;
         end
      end
   endtask

   task automatic check_outputs();
      check("imem_adr", imem_adr, m_fetch);
      check("count_o", 32'(count_o), 32'(mq.size()));
      if (mq.size() != 0) begin
         check("inst_v_o", 32'(inst_v_o), 32'd1);
         check("inst_o", inst_o, mq[0].ins);
         check("inst_pc_o", inst_pc_o, mq[0].pc);
      end else begin
         check("inst_v_o", 32'(inst_v_o), 32'd0);
         check("inst_o_empty", inst_o, 32'd0);
         check("inst_pc_o_empty", inst_pc_o, 32'd0);
      end
   endtask

   // rmode: 0 none, 1 always, 2 only while the response is still >=2 cycles away, 3 only with resp_v
   task automatic step(input bit rdy, input int rmode, input logic [31:0] radr);
      @(negedge clk);
      if (imem_adr !== last_adr) begin
         last_adr = imem_adr;
         age      = 0;
         lat      = lat_rand ? int'($urandom_range(0, 2)) : lat_fixed;
      end
      rv = (age >= lat);
      case (rmode)
         1:       applied = 1'b1;
         2:       applied = !rv && (age + 1 < lat);
         3:       applied = rv;
         default: applied = 1'b0;
      endcase
      imem_resp_v  = rv;
      imem_resp    = word(imem_adr);
      inst_ready_i = rdy;
      redirect_v   = applied;
      redirect_adr = radr;
      check_outputs();
      @(posedge clk);
      age++;
      model_update(rv, applied, rdy, radr);
   endtask

   // Called right after a step's clock edge: asserts reset mid-cycle and checks outputs at once.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_imem_adr", imem_adr, 32'd0);
      check("rst_inst_v_o", 32'(inst_v_o), 32'd0);
      check("rst_inst_o", inst_o, 32'd0);
      check("rst_inst_pc_o", inst_pc_o, 32'd0);
      check("rst_count_o", 32'(count_o), 32'd0);
      model_reset();
      last_adr = 'x;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      // 1. boot and streaming at one instruction per cycle
      start_address = 32'h0001_0000;
      lat_fixed = 0;
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 0, '0);

      // 2. decode stalls until the queue saturates, then drains in order
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b0, 0, '0);
      #1;
      check("full_count", 32'(count_o), 32'd4);
      check("full_stall_adr", imem_adr, 32'h0001_0010);
      for (int i = 0; i < 8; i++) step(1'b1, 0, '0);

      // 3. redirect while a slow response is outstanding
      lat_fixed = 2;
      applied = 1'b0;
      for (int i = 0; i < 20 && !applied; i++) step(1'b1, 2, 32'h0001_0102);
      check("t3_redirect_issued", 32'(applied), 32'd1);
      #1;
      check("t3_flush_count", 32'(count_o), 32'd0);
      for (int i = 0; i < 20 && m_drain; i++) step(1'b1, 0, '0);
      #1;
      check("t3_resume_adr", imem_adr, 32'h0001_0100);
      for (int i = 0; i < 6; i++) step(1'b1, 0, '0);

      // 4. redirect coinciding with a response
      applied = 1'b0;
      for (int i = 0; i < 20 && !applied; i++) step(1'b1, 3, 32'h0001_0400);
      #1;
      check("t4_target_adr", imem_adr, 32'h0001_0400);
      check("t4_not_pushed", 32'(count_o), 32'd0);
      for (int i = 0; i < 6; i++) step(1'b1, 0, '0);

      // 5. second redirect while draining overrides the first
      applied = 1'b0;
      for (int i = 0; i < 20 && !applied; i++) step(1'b1, 2, 32'h0001_0200);
      step(1'b1, 1, 32'h0001_0300);
      for (int i = 0; i < 20 && m_drain; i++) step(1'b1, 0, '0);
      #1;
      check("t5_resume_adr", imem_adr, 32'h0001_0300);
      for (int i = 0; i < 6; i++) step(1'b1, 0, '0);

      // PC wrap past the top of the address space
      lat_fixed = 0;
      step(1'b1, 1, 32'hFFFF_FFFA);
      for (int i = 0; i < 6; i++) step(1'b1, 0, '0);

      // 6. asynchronous reset with three entries queued, then reboot
      for (int i = 0; i < 20 && mq.size() != 3; i++) step(1'b0, 0, '0);
      #1;
      check("t6_pre_reset_count", 32'(count_o), 32'd3);
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 0, '0);

      // randomized traffic: variable latency, decode backpressure, sporadic redirects
      lat_rand = 1'b1;
      start_address = 32'h0002_0006;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0,
              ($urandom_range(0, 15) == 0) ? 1 : 0,
              {16'h0003, 16'($urandom())});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
